mod_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `mod_mul256_p` modular multiplier (mod SM2 prime p) between up to `N_REQ` requesters, such as coordinate conversion, point add and point double. It accepts level-held requests, grants one at a time, drives the multiplier's start pulse, and returns the product with a one-cycle done strobe to the granted requester. It sits between the SM2 point-arithmetic controllers and the single multiplier instance it owns.

---
 rtl/sm2_pkg.sv | 15 +
 rtl/mod_mul_arbiter_if.sv | 26 ++
 rtl/mod_mul256_p.sv | 72 +++++++
 rtl/mod_mul_arbiter.sv | 102 ++++++++++
 tb/tb_mod_mul_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm2_pkg.sv
// SM2 field constants and the state encoding of the shared-multiplier arbiter.
package sm2_pkg;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/mod_mul_arbiter_if.sv
// Requester-side bus of the shared modular-multiplier arbiter.
interface mod_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 256,
  parameter int IDW   = 2
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_done;
  logic [W-1:0]       rsp_c;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  modport master (
    output req, req_a, req_b,
    input  req_done, rsp_c, grant_id, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output req_done, rsp_c, grant_id, busy
  );

endinterface

// File: rtl/mod_mul256_p.sv
// Bit-serial interleaved multiplier mod the SM2 prime: one bit of b per cycle,
// MSB first, done strobe registered together with the final accumulator.
module mod_mul256_p
  import sm2_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] c
);

  localparam int CW = $clog2(W);

  logic          r_run;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;

  // Single conditional subtraction; callers guarantee x < 2p.
  function automatic logic [W-1:0] mod_red(input logic [W:0] x);
    logic [W:0] t;
    t = x - {1'b0, P};
    return (x >= {1'b0, P}) ? t[W-1:0] : x[W-1:0];
  endfunction

  function automatic logic [W-1:0] dbl_add(input logic [W-1:0] acc,
                                           input logic [W-1:0] op,
                                           input logic         b_bit);
    logic [W-1:0] d;
    d = mod_red({acc, 1'b0});
    return mod_red({1'b0, d} + (b_bit ? {1'b0, op} : '0));
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_run) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == '0) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        r_run <= 1'b1;
        r_cnt <= CW'(W - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_run) begin
      r_acc <= dbl_add(r_acc, r_a, r_b[r_cnt]);
    end else if (start) begin
      r_a   <= mod_red({1'b0, a});
      r_b   <= b;
      r_acc <= '0;
    end
  end

  assign done = r_done;
  assign c    = r_acc;

endmodule

// File: rtl/mod_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one mod-p multiplier between N_REQ
// level-held requesters; one operation in flight at a time.
module mod_mul_arbiter
  import sm2_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 256,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  mod_mul_arbiter_if.slave bus
);

  arb_state_t     r_state;
  arb_state_t     w_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_win;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [W-1:0]   r_rsp_c;
  logic [W-1:0]   w_mul_c;
  logic           w_mul_done;
  logic           w_mul_rstn;
  logic           w_start;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0]   ptr);
    logic [N_REQ-1:0] rot;
    int               idx;
    rot = N_REQ'({req, req} >> ptr);
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = k;
    end
    idx = idx + int'(ptr);
    if (idx >= N_REQ) idx = idx - N_REQ;
    return IDW'(idx);
  endfunction

  assign w_win = rr_pick(bus.req, r_rr_ptr);

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    bus.req_done = '0;
    unique case (r_state)
      S_IDLE:  if (|bus.req) w_next = S_ISSUE;
      S_ISSUE: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT:  if (w_mul_done) w_next = S_RESP;
      S_RESP: begin
        bus.req_done[r_grant] = 1'b1;
        w_next                = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rsp_c  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && |bus.req) begin
        r_grant <= w_win;
        r_op_a  <= bus.req_a[int'(w_win)*W +: W];
        r_op_b  <= bus.req_b[int'(w_win)*W +: W];
      end
      // A done seen outside WAIT (e.g. left over from before reset) is dropped.
      if (r_state == S_WAIT && w_mul_done) r_rsp_c <= w_mul_c;
      if (r_state == S_RESP) begin
        r_rr_ptr <= (r_grant == IDW'(N_REQ - 1)) ? '0 : r_grant + IDW'(1);
      end
    end
  end

  assign w_mul_rstn   = ~rst;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_grant;
  assign bus.rsp_c    = r_rsp_c;

  mod_mul256_p u_modmul (
    .clk   (clk),
    .rstn  (w_mul_rstn),
    .start (w_start),
    .a     (r_op_a),
    .b     (r_op_b),
    .done  (w_mul_done),
    .c     (w_mul_c)
  );

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Directed and randomized bench for mod_mul_arbiter with a behavioural
// round-robin and modular-product reference model.
module tb_mod_mul_arbiter;
  import sm2_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int L   = 256;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   m_ptr    = 0;
  int   last_cyc = 0;
  int   last_id  = -1;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] pm1;

  always #5 clk = ~clk;

  mod_mul_arbiter_if #(.N_REQ(N), .W(W), .IDW(IDW)) bus ();

  mod_mul_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mod_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    prod = prod % {{W{1'b0}}, P};
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    if (r >= P) r = r - P;
    return r;
  endfunction

  function automatic int rr_model(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Waits for each response, compares it to the model, then applies the
  // requester rule (drop req unless keep is set).
  task automatic run_ops(input int n, input bit keep);
    int           exp_id;
    int           cyc;
    bit           seen;
    logic [N-1:0] oh;
    logic [W-1:0] exp_c;
    for (int k = 0; k < n; k++) begin
      exp_id = rr_model(bus.req, m_ptr);
      exp_c  = (exp_id >= 0) ? mod_ref(op_a[exp_id], op_b[exp_id]) : '0;
      seen   = 1'b0;
      cyc    = 0;
      while (!seen && cyc < L + 10) begin
        tick();
        cyc++;
        if (bus.req_done != '0) seen = 1'b1;
      end
      last_cyc = cyc;
      chk("done_seen", seen, 1'b1);
      if (seen && exp_id >= 0) begin
        oh = '0;
        oh[exp_id] = 1'b1;
        last_id = exp_id;
        chk("req_done_onehot", bus.req_done, oh);
        chk("rsp_c", bus.rsp_c, exp_c);
        chk("grant_id", bus.grant_id, exp_id);
        chk("busy_resp", bus.busy, 1'b1);
        m_ptr = (exp_id + 1) % N;
        if (!keep) bus.req[exp_id] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    rst       = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    pm1       = P - 1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) tick();
    chk("rst_req_done", bus.req_done, '0);
    chk("rst_rsp_c", bus.rsp_c, '0);
    chk("rst_grant", bus.grant_id, '0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    m_ptr = 0;
    tick();

    // Single request: 2*3, fixed latency, busy falls after the response.
    raise(0, 256'd2, 256'd3);
    run_ops(1, 1'b0);
    chk("single_latency", last_cyc, L + 3);
    chk("single_c", bus.rsp_c, 256'd6);
    tick();
    chk("single_busy_fall", bus.busy, 1'b0);
    chk("single_rsp_hold", bus.rsp_c, 256'd6);

    // Simultaneous requests 0 and 2 straight from reset.
    do_reset();
    raise(0, 256'd5, 256'd7);
    raise(2, rand_fe(), rand_fe());
    run_ops(1, 1'b0);
    chk("sim_first_id", last_id, 0);
    chk("sim_first_c", bus.rsp_c, 256'd35);
    run_ops(1, 1'b0);
    chk("sim_second_id", last_id, 2);
    tick();
    chk("sim_idle", bus.busy, 1'b0);

    // Fairness: all four held, eight operations.
    do_reset();
    for (int i = 0; i < N; i++) raise(i, rand_fe(), rand_fe());
    for (int k = 0; k < 2 * N; k++) begin
      run_ops(1, 1'b1);
      chk("fair_order", last_id, k % N);
    end
    bus.req = '0;
    tick();

    // Boundary operands.
    raise(1, pm1, pm1);
    run_ops(1, 1'b0);
    chk("bnd_pm1_sq", bus.rsp_c, 256'd1);
    tick();
    raise(1, 256'd0, pm1);
    run_ops(1, 1'b0);
    chk("bnd_zero", bus.rsp_c, 256'd0);
    tick();

    // Late arrival of requester 3 during requester 1's WAIT.
    do_reset();
    raise(1, rand_fe(), rand_fe());
    repeat (20) tick();
    chk("late_busy", bus.busy, 1'b1);
    raise(3, rand_fe(), rand_fe());
    run_ops(1, 1'b0);
    chk("late_first", last_id, 1);
    run_ops(1, 1'b0);
    chk("late_second", last_id, 3);
    tick();

    // Reset pulse in the middle of WAIT.
    do_reset();
    raise(2, rand_fe(), rand_fe());
    quiet = 0;
    repeat (50) begin
      tick();
      if (bus.req_done != '0) quiet++;
    end
    chk("midrst_no_early_done", quiet, 0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_grant", bus.grant_id, '0);
    chk("midrst_req_done", bus.req_done, '0);
    rst = 1'b0;
    m_ptr = 0;
    run_ops(1, 1'b0);
    chk("midrst_id", last_id, 2);
    chk("midrst_latency", last_cyc, L + 3);
    tick();

    // Randomized request mixes.
    do_reset();
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 1) == 1) raise(i, rand_fe(), rand_fe());
      end
      if (bus.req == '0) raise(int'($urandom_range(0, N - 1)), rand_fe(), rand_fe());
      run_ops(1, bit'($urandom_range(0, 1)));
    end
    bus.req = '0;
    repeat (3) tick();
    chk("final_idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
